uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver, 8N1, LSB first; counterpart of the UART transmitter.
//  Shares the transmitter's 3-bit baud select table and clocks-per-bit values, so a TX/RX pair on
//  one clk interoperates. Synchronises Rx_Serial, validates the start bit, samples mid-bit, checks
//  the stop bit, and presents the byte with a one-cycle Rx_Done strobe.
// PARAMETERS
//  SYNC_STAGES  2  flops in the Rx_Serial synchroniser (legal values 2..3); all flops reset to 1
// PORTS
//  clk               in   1  single clock; all logic on posedge
//  rst               in   1  synchronous, active-high reset
//  baud_rate_select  in   3  clocks/bit N: 000=1042 001=695 010=521 011=261 100=174 101=87 110=79 111=39
//  Rx_Serial         in   1  asynchronous serial line; idle high
//  Rx_Byte           out  8  last good byte; held until the next good frame
//  Rx_Done           out  1  1-cycle pulse when Rx_Byte updates
//  Rx_Frame_Err      out  1  1-cycle pulse when the stop bit samples 0
//  Rx_Active         out  1  high in START/DATA/STOP states
// BEHAVIOUR
//  - Reset: state IDLE; Rx_Byte=0, Rx_Done=0, Rx_Frame_Err=0, Rx_Active=0; counters 0; sync chain=1.
//    rst mid-frame aborts the frame with no Done or Err pulse.
//  - N: decoded combinationally from baud_rate_select, 11 bits wide. N is latched into an 11-bit
//    register on the IDLE->START transition; a select change mid-frame affects only the next frame.
//    H = N>>1.
//  - rxs = synchroniser output. All state decisions use rxs, never raw Rx_Serial.
//  - States: IDLE, START, DATA, STOP, WAIT_IDLE. clk_count is 11 bits; bit_index is 3 bits.
//  - IDLE: rxs==0 -> START, clk_count=0. Otherwise stay in IDLE.
//  - START: count until clk_count==H-1, then sample.
//    - Sample 0: -> DATA, clk_count=0, bit_index=0.
//    - Sample 1: glitch; -> IDLE with no pulse.
//  - DATA: at clk_count==N-1, sample into shift[bit_index] and clear clk_count.
//    - bit_index==7: -> STOP.
//    - Otherwise: bit_index+1.
//  - STOP: at clk_count==N-1, sample.
//    - Sample 1: Rx_Byte<=shift, Rx_Done=1 for exactly one cycle, -> IDLE.
//    - Sample 0: Rx_Frame_Err=1 for one cycle, Rx_Byte unchanged, -> WAIT_IDLE.
//  - WAIT_IDLE: stay until rxs==1, then -> IDLE. Prevents a stuck-low line from retriggering.
//  - Rx_Done and Rx_Frame_Err are registered, mutually exclusive, never asserted in the same cycle.
//  - Back-to-back frames: a start edge arriving on the cycle after Rx_Done is accepted; no dead cycle
//    beyond the IDLE visit.
//  - Latency: falling edge on Rx_Serial to Rx_Done = SYNC_STAGES + H + 9*N + 2 clocks (+-1).
//  - No overrun detection: a new good frame overwrites Rx_Byte.
// CONFIGURATION
//  UART_RX_MAJORITY_EN
//   - Defined: each sample point (start, data, stop) uses the 2-of-3 majority of rxs at counts
//     T-2, T-1 and T, where T is the decision count (H-1 or N-1). Decision timing is unchanged.
//     Adds a 3-bit history register.
//   - Undefined: single sample of rxs at count T.
//   - Port list and latency are identical in both builds.
// TESTING
//  1. sel=111 (N=39), send 0xA5 8N1 -> one Rx_Done pulse, Rx_Byte=0xA5, Rx_Frame_Err never high,
//     Rx_Active high for ~9.5 bit times.
//  2. sel=111, send 0x00, 0xFF, 0x3C back-to-back with a 1-bit stop -> three Done pulses;
//     Rx_Byte reads 0x00, 0xFF, 0x3C in order.
//  3. sel=111, frame 0x55 with stop bit forced 0, line then held low 5 bit times -> Rx_Frame_Err
//     pulse, Rx_Byte keeps its previous value, no retrigger until line high; next 0x81 received OK.
//  4. sel=111, 10-clk low glitch on idle line -> START aborts at H-1, returns to IDLE; no Done or Err
//     pulse; Rx_Active high less than 20 clks.
//  5. Assert rst during DATA bit 4 of 0xC3 -> next cycle all outputs 0, state IDLE; following 0x5A
//     frame received correctly.
//  6. sel=000 (N=1042), send 0x96; change sel to 111 mid-frame -> 0x96 received correctly; next
//     frame at N=39 also correct. With UART_RX_MAJORITY_EN: 1-clk inversion at each data mid-bit
//     -> byte still correct.

Source files
------------

// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and its user: baud select and serial line in,
// received byte and status strobes out.
interface uart_rx_if;
    logic [2:0] baud_rate_select;
    logic       Rx_Serial;
    logic [7:0] Rx_Byte;
    logic       Rx_Done;
    logic       Rx_Frame_Err;
    logic       Rx_Active;

    modport master (
        output baud_rate_select,
        output Rx_Serial,
        input  Rx_Byte,
        input  Rx_Done,
        input  Rx_Frame_Err,
        input  Rx_Active
    );

    modport slave (
        input  baud_rate_select,
        input  Rx_Serial,
        output Rx_Byte,
        output Rx_Done,
        output Rx_Frame_Err,
        output Rx_Active
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with stop-bit check and frame-error strobe.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 majority of the synchronised line at each sample point.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave rx
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   sample;
    logic [10:0]            n_sel;
    logic [10:0]            n_q, n_d;
    logic [10:0]            h;
    logic [10:0]            clk_count_q, clk_count_d;
    logic [2:0]             bit_index_q, bit_index_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_q, byte_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    // Clocks per bit; must stay identical to the transmitter's table.
    always_comb begin
        case (rx.baud_rate_select)
            3'b000:  n_sel = 11'd1042;
            3'b001:  n_sel = 11'd695;
            3'b010:  n_sel = 11'd521;
            3'b011:  n_sel = 11'd261;
            3'b100:  n_sel = 11'd174;
            3'b101:  n_sel = 11'd87;
            3'b110:  n_sel = 11'd79;
            default: n_sel = 11'd39;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx.Rx_Serial};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];
    assign h   = n_q >> 1;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] tracks rxs itself, so at count T the vote covers rxs at T-2, T-1 and T.
    logic [2:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[1:0], sync_q[SYNC_STAGES-2]};
        end
    end

    assign sample = (hist_q[2] & hist_q[1]) | (hist_q[2] & hist_q[0]) | (hist_q[1] & hist_q[0]);
`else
    assign sample = rxs;
`endif

    // NOTE: every variable written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d     = START;
                    clk_count_d = '0;
                    n_d         = n_sel;
                end
            end

            START: begin
                if (clk_count_q == h - 11'd1) begin
                    clk_count_d = '0;
                    if (!sample) begin
                        state_d     = DATA;
                        bit_index_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_count_d = clk_count_q + 11'd1;
                end
            end

            DATA: begin
                if (clk_count_q == n_q - 11'd1) begin
                    clk_count_d          = '0;
                    shift_d[bit_index_q] = sample;
                    if (bit_index_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 11'd1;
                end
            end

            STOP: begin
                if (clk_count_q == n_q - 11'd1) begin
                    clk_count_d = '0;
                    if (sample) begin
                        byte_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    clk_count_d = clk_count_q + 11'd1;
                end
            end

            // A stuck-low line after a bad stop bit must not look like a new start edge.
            WAIT_IDLE: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rx.Rx_Byte      = byte_q;
    assign rx.Rx_Done      = done_q;
    assign rx.Rx_Frame_Err = err_q;
    assign rx.Rx_Active    = (state_q == START) || (state_q == DATA) || (state_q == STOP);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-built corner sequences,
// with a scoreboard queue matched against every Rx_Done / Rx_Frame_Err pulse.
module tb_uart_rx;
    logic clk;
    logic rst;

    uart_rx_if bus ();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
        logic       stop;
        int         hold_low_bits;
        logic       exp_err;
        logic [7:0] exp_byte;
    } vec_t;

    int   n_vec     = 0;
    int   n_miss    = 0;
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   exp_done  = 0;
    int   exp_err   = 0;
    int   act_cnt   = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int n_of(input logic [2:0] sel);
        case (sel)
            3'b000:  return 1042;
            3'b001:  return 695;
            3'b010:  return 521;
            3'b011:  return 261;
            3'b100:  return 174;
            3'b101:  return 87;
            3'b110:  return 79;
            default: return 39;
        endcase
    endfunction

    task automatic push_exp(input logic is_err, input logic [7:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        sb.push_back(e);
        if (is_err) exp_err++;
        else        exp_done++;
    endtask

    // One bit cell of n clocks starting at the current negedge; cycle g of the cell is inverted.
    task automatic drive_bit(input logic v, input int n, input int g);
        for (int c = 0; c < n; c++) begin
            bus.Rx_Serial = (c == g) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [2:0] sel, input logic [7:0] data, input logic stop,
                             input int glitch_off);
        int n;
        n = n_of(sel);
        bus.baud_rate_select = sel;
        drive_bit(1'b0, n, -1);
        for (int i = 0; i < 8; i++) drive_bit(data[i], n, glitch_off);
        drive_bit(stop, n, -1);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("scoreboard_drain", sb.size(), 0);
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.Rx_Active) act_cnt++;
        if (!rst) begin
            if (prev_done) check("done_pulse_width", bus.Rx_Done, 0);
            if (prev_err)  check("err_pulse_width", bus.Rx_Frame_Err, 0);
            if (bus.Rx_Done || bus.Rx_Frame_Err) begin
                check("done_err_exclusive", bus.Rx_Done & bus.Rx_Frame_Err, 0);
                if (bus.Rx_Done) done_cnt++;
                else             err_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {bus.Rx_Done, bus.Rx_Frame_Err}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_kind_is_err", bus.Rx_Frame_Err, mon_e.is_err);
                    check("rx_byte", bus.Rx_Byte, mon_e.data);
                end
            end
        end
        prev_done = bus.Rx_Done & ~rst;
        prev_err  = bus.Rx_Frame_Err & ~rst;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at t=%0t, wanted completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[9];
        int         lat;
        int         lat_exp;
        int         n;
        int         done_before;
        int         err_before;
        logic [7:0] v;

        vecs[0] = '{3'b111, 8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[1] = '{3'b111, 8'hFF, 1'b1, 0, 1'b0, 8'hFF};
        vecs[2] = '{3'b111, 8'h3C, 1'b1, 0, 1'b0, 8'h3C};
        vecs[3] = '{3'b110, 8'h5A, 1'b1, 0, 1'b0, 8'h5A};
        vecs[4] = '{3'b101, 8'hC3, 1'b1, 0, 1'b0, 8'hC3};
        vecs[5] = '{3'b100, 8'h81, 1'b1, 0, 1'b0, 8'h81};
        vecs[6] = '{3'b011, 8'h7E, 1'b1, 0, 1'b0, 8'h7E};
        vecs[7] = '{3'b111, 8'h55, 1'b0, 5, 1'b1, 8'h7E};
        vecs[8] = '{3'b111, 8'h81, 1'b1, 0, 1'b0, 8'h81};

        rst                  = 1'b1;
        bus.Rx_Serial        = 1'b1;
        bus.baud_rate_select = 3'b111;
        repeat (3) @(negedge clk);
        check("reset_rx_byte", bus.Rx_Byte, 8'h00);
        check("reset_rx_done", bus.Rx_Done, 0);
        check("reset_frame_err", bus.Rx_Frame_Err, 0);
        check("reset_rx_active", bus.Rx_Active, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame: latency from the falling start edge and busy time.
        push_exp(1'b0, 8'hA5);
        act_cnt = 0;
        lat     = 0;
        lat_exp = 2 + 19 + 9 * 39 + 2;
        fork
            send_byte(3'b111, 8'hA5, 1'b1, -1);
            begin
                for (int c = 0; c < 600; c++) begin
                    @(negedge clk);
                    lat++;
                    if (bus.Rx_Done) break;
                end
            end
        join
        wait_drain(200);
        repeat (5) @(negedge clk);
        check("latency_within_1", (lat >= lat_exp - 1 && lat <= lat_exp + 1) ? 1 : 0, 1);
        check("active_about_9p5_bits", (act_cnt >= 9 * 39 && act_cnt <= 10 * 39) ? 1 : 0, 1);

        // Table: back-to-back frames, several baud rates, a bad stop bit with a stuck-low line.
        for (int i = 0; i < 9; i++) begin
            push_exp(vecs[i].exp_err, vecs[i].exp_byte);
            send_byte(vecs[i].sel, vecs[i].data, vecs[i].stop, -1);
            if (vecs[i].hold_low_bits > 0) begin
                n = n_of(vecs[i].sel);
                repeat (vecs[i].hold_low_bits * n / 2) @(negedge clk);
                check("active_low_in_wait_idle", bus.Rx_Active, 0);
                repeat (vecs[i].hold_low_bits * n - vecs[i].hold_low_bits * n / 2) @(negedge clk);
                bus.Rx_Serial = 1'b1;
                repeat (2 * n) @(negedge clk);
            end
        end
        wait_drain(2000);

        // Short low glitch on an idle line: START entered then abandoned, no strobes.
        repeat (50) @(negedge clk);
        done_before = done_cnt;
        err_before  = err_cnt;
        act_cnt     = 0;
        bus.Rx_Serial = 1'b0;
        repeat (10) @(negedge clk);
        bus.Rx_Serial = 1'b1;
        repeat (3 * 39) @(negedge clk);
        check("glitch_active_short", (act_cnt > 0 && act_cnt < 20) ? 1 : 0, 1);
        check("glitch_no_done", done_cnt, done_before);
        check("glitch_no_err", err_cnt, err_before);

        // Reset in the middle of data bit 4, then a clean frame.
        v = 8'hC3;
        bus.baud_rate_select = 3'b111;
        drive_bit(1'b0, 39, -1);
        for (int i = 0; i < 4; i++) drive_bit(v[i], 39, -1);
        bus.Rx_Serial = v[4];
        repeat (19) @(negedge clk);
        check("pre_reset_active", bus.Rx_Active, 1);
        rst           = 1'b1;
        bus.Rx_Serial = 1'b1;
        @(negedge clk);
        check("midframe_rst_rx_byte", bus.Rx_Byte, 8'h00);
        check("midframe_rst_done", bus.Rx_Done, 0);
        check("midframe_rst_err", bus.Rx_Frame_Err, 0);
        check("midframe_rst_active", bus.Rx_Active, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        push_exp(1'b0, 8'h5A);
        send_byte(3'b111, 8'h5A, 1'b1, -1);
        wait_drain(200);

        // Slowest rate with the select changed mid-frame, then a frame at the new rate.
        push_exp(1'b0, 8'h96);
        fork
            send_byte(3'b000, 8'h96, 1'b1, -1);
            begin
                repeat (5000) @(negedge clk);
                bus.baud_rate_select = 3'b111;
            end
        join
        push_exp(1'b0, 8'h69);
        send_byte(3'b111, 8'h69, 1'b1, -1);
        wait_drain(200);

`ifdef UART_RX_MAJORITY_EN
        // One-clock inversion at each data mid-bit is outvoted.
        push_exp(1'b0, 8'h96);
        send_byte(3'b111, 8'h96, 1'b1, 19);
        wait_drain(200);
`endif

        repeat (20) @(negedge clk);
        check("total_done_pulses", done_cnt, exp_done);
        check("total_err_pulses", err_cnt, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
